// File: rtl/plru_state_array_if.sv
// Lookup/touch bus between a cache controller (master) and the PLRU state array (slave).
interface plru_state_array_if #(
  parameter int s_way   = 2,
  parameter int s_index = 3
);
  localparam int num_ways = 2**s_way;

  logic                  ready;
  logic                  rd_valid;
  logic [s_index-1:0]    rd_index;
  logic                  victim_valid;
  logic [num_ways-1:0]   victim_way;
  logic [num_ways-2:0]   victim_lru;
  logic                  upd_valid;
  logic [s_index-1:0]    upd_index;
  logic [num_ways-1:0]   upd_way;

  modport master (
    input  ready, victim_valid, victim_way, victim_lru,
    output rd_valid, rd_index, upd_valid, upd_index, upd_way
  );

  modport slave (
    output ready, victim_valid, victim_way, victim_lru,
    input  rd_valid, rd_index, upd_valid, upd_index, upd_way
  );
endinterface

// File: rtl/plru_state_array.sv
// Per-set tree pseudo-LRU storage: registered victim lookup, touch update, zeroing sweep after reset.
// Optional PLRU_BYPASS_EN: a same-edge lookup of the set being touched sees the post-update tree.
module plru_state_array #(
  parameter int s_way   = 2,
  parameter int s_index = 3
) (
  input  logic clk,
  input  logic rst,
  plru_state_array_if.slave bus
);
  localparam int num_ways = 2**s_way;
  localparam int num_sets = 2**s_index;

  typedef logic [num_ways-2:0] tree_t;
  typedef logic [num_ways-1:0] way_t;
  typedef logic [s_index-1:0]  index_t;
  typedef enum logic { INIT, READY } state_e;

  // Lowest set bit of a way vector, as a way number.
  function automatic int lowest_way(way_t w);
    way_t sh;
    int   r;
    r = 0;
    for (int i = num_ways-1; i >= 0; i--) begin
      sh = w >> i;
      if (sh[0]) r = i;
    end
    return r;
  endfunction

  // Point every node on way w's path away from it.
  function automatic tree_t touch(tree_t t, int w);
    tree_t r;
    int    idx;
    r = t;
    for (int i = 0; i < s_way; i++) begin
      idx = (1 << i) - 1 + (w >> (s_way - i));
      if (((w >> (s_way-1-i)) & 1) == 0) r = r | (tree_t'(1) << idx);
      else                               r = r & ~(tree_t'(1) << idx);
    end
    return r;
  endfunction

  function automatic way_t victim_of(tree_t t);
    tree_t sh;
    int    node;
    node = 0;
    for (int i = 0; i < s_way; i++) begin
      sh   = t >> ((1 << i) - 1 + node);
      node = 2*node + (sh[0] ? 1 : 0);
    end
    return way_t'(1) << node;
  endfunction

  tree_t  mem_q [num_sets];
  state_e state_q, state_d;
  index_t cnt_q, cnt_d;
  logic   ready_q, ready_d;
  logic   victim_valid_q, victim_valid_d;
  way_t   victim_way_q, victim_way_d;
  tree_t  victim_lru_q, victim_lru_d;

  logic   rd_en, upd_en, wr_en;
  index_t wr_idx;
  tree_t  wr_data, upd_tree, rd_tree;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == index_t'(num_sets-1)) state_d = READY;
    end
    ready_d = (state_d == READY);

    rd_en    = bus.rd_valid && (state_q == READY);
    upd_en   = bus.upd_valid && (state_q == READY) && (|bus.upd_way);
    upd_tree = touch(mem_q[bus.upd_index], lowest_way(bus.upd_way));

    // The sweep owns the single write port while initialising.
    wr_en   = (state_q == INIT) || upd_en;
    wr_idx  = (state_q == INIT) ? cnt_q : bus.upd_index;
    wr_data = (state_q == INIT) ? '0 : upd_tree;

    rd_tree = mem_q[bus.rd_index];
`ifdef PLRU_BYPASS_EN
    if (upd_en && (bus.upd_index == bus.rd_index)) rd_tree = upd_tree;
`endif

    victim_valid_d = rd_en;
    victim_lru_d   = rd_en ? rd_tree : victim_lru_q;
    victim_way_d   = rd_en ? victim_of(rd_tree) : victim_way_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= INIT;
      cnt_q          <= '0;
      ready_q        <= 1'b0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_lru_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ready_q        <= ready_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      victim_lru_q   <= victim_lru_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign bus.ready        = ready_q;
  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way   = victim_way_q;
  assign bus.victim_lru   = victim_lru_q;
endmodule

// File: tb/tb_plru_state_array.sv
// Directed bench for plru_state_array with s_way=2, s_index=3.
module tb_plru_state_array;
  localparam int s_way   = 2;
  localparam int s_index = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  plru_state_array_if #(.s_way(s_way), .s_index(s_index)) bus();
  plru_state_array #(.s_way(s_way), .s_index(s_index)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int passes = 0;

  logic [2:0] lru;
  logic [3:0] way;
  logic       vld;
  int         n;

  task automatic idle();
    bus.rd_valid  = 1'b0;
    bus.rd_index  = '0;
    bus.upd_valid = 1'b0;
    bus.upd_index = '0;
    bus.upd_way   = '0;
  endtask

  // Leaves time at 1 unit after a rising edge with rst low.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bus.ready && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic reset_and_init(output int cnt);
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(cnt);
  endtask

  task automatic lookup(input logic [2:0] idx, output logic [2:0] l, output logic [3:0] w,
                        output logic v);
    bus.rd_valid = 1'b1;
    bus.rd_index = idx;
    @(posedge clk); #1;
    bus.rd_valid = 1'b0;
    l = bus.victim_lru;
    w = bus.victim_way;
    v = bus.victim_valid;
  endtask

  task automatic update(input logic [2:0] idx, input logic [3:0] w);
    bus.upd_valid = 1'b1;
    bus.upd_index = idx;
    bus.upd_way   = w;
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #3 rst = 1'b1;
    #4;
    checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.ready); else passes++;
    checks++; if (bus.victim_valid !== 1'b0) $display("FAIL reset_vvalid got %b want 0", bus.victim_valid); else passes++;
    checks++; if (bus.victim_way !== 4'b0000) $display("FAIL reset_way got %b want 0000", bus.victim_way); else passes++;
    checks++; if (bus.victim_lru !== 3'b000) $display("FAIL reset_lru got %b want 000", bus.victim_lru); else passes++;
  endtask

  task automatic test_init();
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(n);
    checks++; if (n !== 8) $display("FAIL init_edges got %0d want 8", n); else passes++;
    for (int s = 0; s < 8; s++) begin
      lookup(3'(s), lru, way, vld);
      checks++;
      if (vld !== 1'b1 || lru !== 3'b000 || way !== 4'b0001)
        $display("FAIL init_set%0d got v=%b lru=%b way=%b want v=1 lru=000 way=0001", s, vld, lru, way);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (bus.victim_valid !== 1'b0) $display("FAIL init_vvalid_drop%0d got %b want 0", s, bus.victim_valid);
      else passes++;
    end
  endtask

  task automatic test_update_lookup();
    update(3'd5, 4'b0001);
    lookup(3'd5, lru, way, vld);
    checks++; if (lru !== 3'b011 || way !== 4'b0100)
      $display("FAIL upd_way0 got lru=%b way=%b want 011 0100", lru, way); else passes++;
    update(3'd5, 4'b0100);
    lookup(3'd5, lru, way, vld);
    checks++; if (lru !== 3'b110 || way !== 4'b0010)
      $display("FAIL upd_way2 got lru=%b way=%b want 110 0010", lru, way); else passes++;
    lookup(3'd4, lru, way, vld);
    checks++; if (lru !== 3'b000 || way !== 4'b0001)
      $display("FAIL upd_other_set got lru=%b way=%b want 000 0001", lru, way); else passes++;
  endtask

  task automatic test_back_to_back();
    // way3 then way1 on set 7: 000 -> 000 (root 0, node2 0) -> 001
    bus.upd_valid = 1'b1; bus.upd_index = 3'd7; bus.upd_way = 4'b1000;
    @(posedge clk); #1;
    bus.upd_way = 4'b0010;
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    lookup(3'd7, lru, way, vld);
    checks++; if (lru !== 3'b001 || way !== 4'b0100)
      $display("FAIL b2b_compose got lru=%b way=%b want 001 0100", lru, way); else passes++;
  endtask

  task automatic test_collision();
    reset_and_init(n);
    checks++; if (n !== 8) $display("FAIL coll_init_edges got %0d want 8", n); else passes++;
    bus.rd_valid  = 1'b1; bus.rd_index  = 3'd3;
    bus.upd_valid = 1'b1; bus.upd_index = 3'd3; bus.upd_way = 4'b0010;
    @(posedge clk); #1;
    idle();
`ifdef PLRU_BYPASS_EN
    checks++; if (bus.victim_lru !== 3'b001 || bus.victim_way !== 4'b0100 || bus.victim_valid !== 1'b1)
      $display("FAIL collision got lru=%b way=%b want 001 0100", bus.victim_lru, bus.victim_way); else passes++;
`else
    checks++; if (bus.victim_lru !== 3'b000 || bus.victim_way !== 4'b0001 || bus.victim_valid !== 1'b1)
      $display("FAIL collision got lru=%b way=%b want 000 0001", bus.victim_lru, bus.victim_way); else passes++;
`endif
    lookup(3'd3, lru, way, vld);
    checks++; if (lru !== 3'b001) $display("FAIL collision_after got lru=%b want 001", lru); else passes++;
  endtask

  task automatic test_sanitize();
    update(3'd2, 4'b1010);
    lookup(3'd2, lru, way, vld);
    checks++; if (lru !== 3'b001 || way !== 4'b0100)
      $display("FAIL sanitize_multi got lru=%b way=%b want 001 0100", lru, way); else passes++;
    update(3'd2, 4'b0000);
    lookup(3'd2, lru, way, vld);
    checks++; if (lru !== 3'b001) $display("FAIL sanitize_zero got lru=%b want 001", lru); else passes++;
  endtask

  task automatic test_init_requests();
    int bad;
    bad = 0;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (!bus.ready && n < 40) begin
      bus.rd_valid  = 1'b1; bus.rd_index  = 3'd1;
      bus.upd_valid = 1'b1; bus.upd_index = 3'd1; bus.upd_way = 4'b0001;
      @(posedge clk); #1;
      if (bus.victim_valid !== 1'b0) bad++;
      n++;
    end
    idle();
    checks++; if (n !== 8) $display("FAIL initreq_edges got %0d want 8", n); else passes++;
    checks++; if (bad !== 0) $display("FAIL initreq_vvalid got %0d high cycles want 0", bad); else passes++;
    lookup(3'd1, lru, way, vld);
    checks++; if (lru !== 3'b000 || way !== 4'b0001)
      $display("FAIL initreq_set1 got lru=%b way=%b want 000 0001", lru, way); else passes++;
  endtask

  task automatic test_mid_reset();
    update(3'd6, 4'b0001);
    lookup(3'd6, lru, way, vld);
    checks++; if (lru !== 3'b011) $display("FAIL midrst_pre got lru=%b want 011", lru); else passes++;
    bus.rd_valid = 1'b1; bus.rd_index = 3'd6;
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b0 || bus.victim_valid !== 1'b0)
      $display("FAIL midrst_immediate got ready=%b vvalid=%b want 0 0", bus.ready, bus.victim_valid); else passes++;
    checks++; if (bus.victim_lru !== 3'b000 || bus.victim_way !== 4'b0000)
      $display("FAIL midrst_outputs got lru=%b way=%b want 000 0000", bus.victim_lru, bus.victim_way); else passes++;
    @(posedge clk); #1;
    checks++; if (bus.victim_valid !== 1'b0) $display("FAIL midrst_stale got %b want 0", bus.victim_valid); else passes++;
    idle();
    rst = 1'b0;
    wait_ready(n);
    checks++; if (n !== 8) $display("FAIL midrst_edges got %0d want 8", n); else passes++;
    lookup(3'd6, lru, way, vld);
    checks++; if (lru !== 3'b000 || way !== 4'b0001)
      $display("FAIL midrst_set6 got lru=%b way=%b want 000 0001", lru, way); else passes++;
  endtask

  initial begin
    test_reset();
    test_init();
    test_update_lookup();
    test_back_to_back();
    test_collision();
    test_sanitize();
    test_init_requests();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/plru_state_array.md
# plru_state_array

Per-set storage and update engine for tree pseudo-LRU state in a set-associative cache. It holds one (num_ways-1)-bit tree per set and returns a registered victim way for a looked-up set. On each hit or fill it rewrites the accessed set's tree so that every node on the accessed way's path points away from it. It sits beside the tag/data arrays and is the stateful counterpart of the combinational victim-decode/update logic: it reads trees out, writes updated trees back, and owns initialisation.

## Interface
- s_way, 2, log2 of associativity
- num_ways, 2**s_way, number of ways
- s_index, 3, log2 of set count
- num_sets, 2**s_index, number of sets

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ready  output  1  high once initialisation is done; lookups and updates are accepted only while high
- rd_valid  input  1  lookup request
- rd_index  input  s_index  set to look up
- victim_valid  output  1  victim_way/victim_lru are valid this cycle
- victim_way  output  num_ways  one-hot victim for the looked-up set
- victim_lru  output  num_ways-1  tree bits of the looked-up set
- upd_valid  input  1  touch request (hit or fill)
- upd_index  input  s_index  set being touched
- upd_way  input  num_ways  accessed way; lowest set bit wins, all-zero means no-op

## Operation
- Tree layout: node k of level i is bit 2**i-1+k. Its children are nodes 2k and 2k+1 of level i+1. At the last level, the children are ways 2k and 2k+1.
- Victim walk: starting at the root, node bit 0 selects the even child and 1 selects the odd child. An all-zero tree gives way 0.
- Touch update: for each node on the accessed way's path, set the bit to 1 if the path goes to the even child and 0 if it goes to the odd child. Nodes off the path keep their value.
- Storage array has no reset. Only control flops are reset.
- FSM states: INIT and READY.
  - rst drives the FSM to INIT with the sweep counter at 0.
  - In INIT, each cycle writes all-zero to set[counter] and increments the counter.
  - When the counter reaches num_sets-1, the FSM moves to READY. READY holds until rst.
- In INIT, rd_valid and upd_valid are ignored: no lookup result and no write.
- upd_way with more than one bit set is reduced to its lowest set bit. All-zero upd_way with upd_valid high writes nothing.

## Timing
- Reset values: ready=0, victim_valid=0, victim_way=0, victim_lru=0, sweep counter=0.
- Initialisation: ready rises after the num_sets-th rising edge following rst deassertion.
- Lookup latency: one cycle.
  - rd_valid sampled high in READY at edge t gives victim_valid=1 with the registered result during cycle t+1.
  - If rd_valid is low at edge t, victim_valid=0 in cycle t+1. victim_way and victim_lru hold their previous values.
- Updates are written at the edge that samples upd_valid. A lookup of the same set at any later edge sees the new tree.
- Lookup and update of the same set at the same edge: behaviour is set by PLRU_BYPASS_EN (see Configuration).
- Lookup and update of different sets at the same edge are independent.
- Back-to-back updates to one set compose in order: each update reads the tree as left by the previous one.
- rst asserted mid-operation clears ready, victim_valid and the outputs immediately, then re-runs INIT. Tree contents are rewritten to zero by the sweep.

## Configuration
- PLRU_BYPASS_EN defined: a same-edge lookup and update to the same index returns the post-update tree and the matching victim.
- PLRU_BYPASS_EN undefined: that lookup returns the pre-update tree and its victim. The write still lands at the same edge.

## Test plan
(All scenarios use s_way=2, s_index=3.)
- Init: deassert rst and hold all requests low. ready must rise after exactly 8 edges. Then look up sets 0..7: each returns victim_lru=3'b000, victim_way=4'b0001, victim_valid high for one cycle each.
- Update and lookup: update set 5 with upd_way 4'b0001, then look up set 5 → 3'b011, 4'b0100. Next, update set 5 with 4'b0100 and look up set 5 → 3'b110, 4'b0010. Set 4 must still read 3'b000.
- Same-edge collision: from a fresh init, update and look up set 3 at the same edge with upd_way 4'b0010.
  - With PLRU_BYPASS_EN: 3'b001, 4'b0100.
  - Without it: 3'b000, 4'b0001.
  - In both cases a following lookup of set 3 returns 3'b001.
- Way sanitising: update set 2 with 4'b1010 → behaves as 4'b0010 (reads 3'b001). Update with 4'b0000 → tree is unchanged.
- Requests during INIT: drive rd_valid and upd_valid to set 1 (way 4'b0001) in every INIT cycle. victim_valid must stay 0, and set 1 must read 3'b000 after ready.
- Mid-operation reset: write set 6 to 3'b011, then pulse rst during a pending lookup.
  - ready and victim_valid must go 0 immediately, with no stale result the next cycle.
  - After 8 edges ready rises again and set 6 reads 3'b000.
